// File: rtl/uart_rx_if.sv
`timescale 1ns/1ps
// uart_rx_if
//   Bundles the serial line and the parallel receive-side signals of the
//   board-to-board UART link.
//   Signals:
//     serial_in  1  serial line from the remote board, idle high
//     data_out   8  last correctly framed byte, bit 0 = first data bit
//     Rx_Done    1  1-cycle pulse when data_out takes a new byte
//     Rx_Active  1  high while a frame is being received
//     Frame_Err  1  last frame ended with a stop bit sampled low
//   Modports:
//     master  the receiver: consumes serial_in, drives the parallel side
//     slave   the line driver / byte consumer on the other side
interface uart_rx_if;
  logic       serial_in;
  logic [7:0] data_out;
  logic       Rx_Done;
  logic       Rx_Active;
  logic       Frame_Err;

  modport master (
    input  serial_in,
    output data_out,
    output Rx_Done,
    output Rx_Active,
    output Frame_Err
  );

  modport slave (
    output serial_in,
    input  data_out,
    input  Rx_Done,
    input  Rx_Active,
    input  Frame_Err
  );
endinterface

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx
//   8N1 UART receiver, LSB first. Synchronises the asynchronous serial line
//   into clk, validates the start bit at mid-bit, samples each data bit at
//   mid-bit and presents the byte with a 1-cycle done strobe and a framing
//   error flag.
//   Ports:
//     clk    in  internal clock, all logic on posedge
//     rst_n  in  asynchronous active-low reset
//     bus    uart_rx_if.master: serial_in in; data_out, Rx_Done,
//            Rx_Active, Frame_Err out (all outputs registered)
module uart_rx #(
  parameter int clk_freq     = 50000000,
  parameter int baudrate     = 115200,
  parameter int clks_per_bit = clk_freq / baudrate
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_rx_if.master bus
);

  localparam int CNT_W = $clog2(clks_per_bit);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((clks_per_bit - 1) / 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(clks_per_bit - 1);

  typedef enum logic [2:0] {
    IDLE,
    RECV_START_BIT,
    RECV_DATA_BITS,
    RECV_STOP_BIT,
    CLEANUP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             done_q, done_d;
  logic             active_q, active_d;
  logic             ferr_q, ferr_d;
  logic             armed_q, armed_d;
  logic [1:0]       sync_q;
  logic             rx_s;

  // Two-flop synchroniser; resets to the idle line level so reset never
  // looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], bus.serial_in};
    end
  end

  assign rx_s = sync_q[1];

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      active_q  <= 1'b0;
      ferr_q    <= 1'b0;
      armed_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      active_q  <= active_d;
      ferr_q    <= ferr_d;
      armed_q   <= armed_d;
    end
  end

  // Next-state logic. The baud counter is always cleared at its terminal
  // value, so it never wraps. armed drops after a framing error so a line
  // held low cannot retrigger until it has been seen high again.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    active_d  = active_q;
    ferr_d    = ferr_q;
    armed_d   = armed_q;

    case (state_q)
      IDLE: begin
        count_d   = '0;
        bit_idx_d = '0;
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d  = RECV_START_BIT;
          active_d = 1'b1;
          ferr_d   = 1'b0;
        end
      end

      RECV_START_BIT: begin
        if (count_q == HALF_CNT) begin
          count_d = '0;
          if (!rx_s) begin
            state_d = RECV_DATA_BITS;
          end else begin
            state_d  = IDLE;
            active_d = 1'b0;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      RECV_DATA_BITS: begin
        if (count_q == FULL_CNT) begin
          count_d           = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = RECV_STOP_BIT;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      RECV_STOP_BIT: begin
        if (count_q == FULL_CNT) begin
          count_d  = '0;
          active_d = 1'b0;
          state_d  = CLEANUP;
          if (rx_s) begin
            data_d = shift_q;
            done_d = 1'b1;
            ferr_d = 1'b0;
          end else begin
            ferr_d  = 1'b1;
            armed_d = 1'b0;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      CLEANUP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.data_out  = data_q;
  assign bus.Rx_Done   = done_q;
  assign bus.Rx_Active = active_q;
  assign bus.Frame_Err = ferr_q;

endmodule
